// File: rtl/wdg_multi_pkg.sv
// Shared types for the wdg_multi watchdog: channel FSM encoding and the
// per-cycle event priority used to resolve simultaneous channel events.
package wdg_multi_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StS1      = 2'd1,
        StS2      = 2'd2,
        StExpired = 2'd3
    } wdg_state_e;

    // Numerically larger events win when several hit a channel in one cycle.
    typedef enum logic [2:0] {
        EvNone    = 3'd0,
        EvTick    = 3'd1,
        EvKick    = 3'd2,
        EvClrS1   = 3'd3,
        EvDisable = 3'd4
    } wdg_event_e;

    function automatic wdg_event_e pick_event(
        input logic dis_req,
        input logic clr_s1_req,
        input logic kick_req,
        input logic tick_req
    );
        if (dis_req) return EvDisable;
        if (clr_s1_req) return EvClrS1;
        if (kick_req) return EvKick;
        if (tick_req) return EvTick;
        return EvNone;
    endfunction

endpackage

// File: rtl/wdg_channel.sv
// One watchdog channel: two-stage timeout FSM, counter, sticky flags and the
// optional early-kick window check (enabled by defining WDG_WINDOW_EN).
module wdg_channel
    import wdg_multi_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 tick,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] timeout,
    input  logic [CNT_WIDTH-1:0] window,
    input  logic                 kick,
    input  logic                 clr_s1,
    input  logic                 clr_s2,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 s1wto,
    output logic                 s2wto,
    output logic                 bad_kick
);

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    wdg_state_e           state_q, state_d;
    wdg_event_e           ev;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, reload;
    logic                 s1_q, s1_d, s2_q, s2_d, bad_q, bad_d;
    logic                 s1_set, s2_set, kick_ok;

    // A zero timeout would never expire through the cnt == 1 check.
    assign reload = (timeout == '0) ? CntOne : timeout;

`ifdef WDG_WINDOW_EN
    assign kick_ok = (cnt_q <= window);
`else
    logic unused_window;
    assign unused_window = ^window;
    assign kick_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bad_d   = 1'b0;
        s1_set  = 1'b0;
        s2_set  = 1'b0;
        ev      = pick_event(!en, clr_s1 && (state_q == StS2), kick && (state_q == StS1),
                             tick && ((state_q == StS1) || (state_q == StS2)));
        unique case (ev)
            EvDisable: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            EvClrS1: begin
                state_d = StS1;
                cnt_d   = reload;
            end
            EvKick: begin
                cnt_d = reload;
                if (!kick_ok) begin
                    bad_d   = 1'b1;
                    s1_set  = 1'b1;
                    state_d = StS2;
                end
            end
            EvTick: begin
                if (cnt_q <= CntOne) begin
                    if (state_q == StS1) begin
                        s1_set  = 1'b1;
                        cnt_d   = reload;
                        state_d = StS2;
                    end else begin
                        s2_set  = 1'b1;
                        cnt_d   = '0;
                        state_d = StExpired;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                // en is known high here, so an idle channel arms itself.
                if (state_q == StIdle) begin
                    state_d = StS1;
                    cnt_d   = reload;
                end
            end
        endcase
        s1_d = s1_set | (s1_q & ~clr_s1);
        s2_d = s2_set | (s2_q & ~clr_s2);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            bad_q   <= bad_d;
        end
    end

    assign cnt      = cnt_q;
    assign s1wto    = s1_q;
    assign s2wto    = s2_q;
    assign bad_kick = bad_q;

endmodule

// File: rtl/wdg_multi.sv
// Multi-channel two-stage watchdog top: shared tick prescaler, per-channel
// bus slicing and IRQ reduction. Early-kick window enabled by WDG_WINDOW_EN.
module wdg_multi #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned PRESCALE_WIDTH = 20
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic [PRESCALE_WIDTH-1:0]     i_prescale,
    input  logic [NUM_CH-1:0]             i_en,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   i_timeout,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   i_window,
    input  logic [NUM_CH-1:0]             i_kick,
    input  logic [NUM_CH-1:0]             i_clr_s1,
    input  logic [NUM_CH-1:0]             i_clr_s2,
    output logic [NUM_CH*CNT_WIDTH-1:0]   o_cnt,
    output logic [NUM_CH-1:0]             o_s1wto,
    output logic [NUM_CH-1:0]             o_s2wto,
    output logic [NUM_CH-1:0]             o_bad_kick,
    output logic                          o_irq1,
    output logic                          o_irq2
);

    logic [PRESCALE_WIDTH-1:0] pre_q;
    logic                      tick;

    assign tick = (pre_q == i_prescale);

    // Counter above a freshly lowered period wraps silently (no tick).
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pre_q <= '0;
        end else if (pre_q >= i_prescale) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRESCALE_WIDTH'(1);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        wdg_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .clk      (clk),
            .res      (res),
            .tick     (tick),
            .en       (i_en[k]),
            .timeout  (i_timeout[k*CNT_WIDTH +: CNT_WIDTH]),
            .window   (i_window[k*CNT_WIDTH +: CNT_WIDTH]),
            .kick     (i_kick[k]),
            .clr_s1   (i_clr_s1[k]),
            .clr_s2   (i_clr_s2[k]),
            .cnt      (o_cnt[k*CNT_WIDTH +: CNT_WIDTH]),
            .s1wto    (o_s1wto[k]),
            .s2wto    (o_s2wto[k]),
            .bad_kick (o_bad_kick[k])
        );
    end

    assign o_irq1 = |o_s1wto;
    assign o_irq2 = |o_s2wto;

endmodule

// File: tb/tb_wdg_multi.sv
// Directed self-checking bench for wdg_multi with two channels; the window
// scenario follows whichever WDG_WINDOW_EN build is being simulated.
module tb_wdg_multi;

    localparam int unsigned NCH = 2;
    localparam int unsigned CW  = 16;
    localparam int unsigned PW  = 20;

    logic              clk = 1'b0;
    logic              res = 1'b1;
    logic [PW-1:0]     i_prescale = '0;
    logic [NCH-1:0]    i_en = '0, i_kick = '0, i_clr_s1 = '0, i_clr_s2 = '0;
    logic [NCH*CW-1:0] i_timeout = '0, i_window = '1;
    logic [NCH*CW-1:0] o_cnt;
    logic [NCH-1:0]    o_s1wto, o_s2wto, o_bad_kick;
    logic              o_irq1, o_irq2;
    logic [CW-1:0]     cnt0;

    int checks = 0;
    int errors = 0;

    assign cnt0 = o_cnt[CW-1:0];

    wdg_multi #(
        .NUM_CH(NCH),
        .CNT_WIDTH(CW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .clk        (clk),
        .res        (res),
        .i_prescale (i_prescale),
        .i_en       (i_en),
        .i_timeout  (i_timeout),
        .i_window   (i_window),
        .i_kick     (i_kick),
        .i_clr_s1   (i_clr_s1),
        .i_clr_s2   (i_clr_s2),
        .o_cnt      (o_cnt),
        .o_s1wto    (o_s1wto),
        .o_s2wto    (o_s2wto),
        .o_bad_kick (o_bad_kick),
        .o_irq1     (o_irq1),
        .o_irq2     (o_irq2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Disable both channels, clear every flag and let the prescaler settle.
    task automatic idle_all();
        i_en = '0;
        i_kick = '0;
        i_clr_s1 = '1;
        i_clr_s2 = '1;
        step();
        i_clr_s1 = '0;
        i_clr_s2 = '0;
        step();
        step();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({o_cnt, o_s1wto, o_s2wto, o_bad_kick, o_irq1, o_irq2} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got cnt=%h s1=%b s2=%b bk=%b irq=%b%b expected all 0",
                     o_cnt, o_s1wto, o_s2wto, o_bad_kick, o_irq1, o_irq2);
        end
        @(negedge clk);
        res = 1'b0;
        step();
        checks++;
        if ({o_cnt, o_s1wto, o_s2wto, o_bad_kick, o_irq1, o_irq2} !== '0) begin
            errors++;
            $display("FAIL reset_release: got cnt=%h s1=%b s2=%b bk=%b expected all 0",
                     o_cnt, o_s1wto, o_s2wto, o_bad_kick);
        end
    endtask

    task automatic test_basic_expiry();
        logic [CW-1:0] e0, e1;
        logic [1:0] es1, es2;
        i_prescale = '0;
        i_timeout[CW-1:0] = 16'd5;
        i_timeout[2*CW-1:CW] = 16'd7;
        idle_all();
        i_en = 2'b11;
        step();
        for (int n = 0; n <= 16; n++) begin
            if (n > 0) step();
            e0 = (n < 5) ? CW'(5 - n) : (n < 10) ? CW'(10 - n) : '0;
            e1 = (n < 7) ? CW'(7 - n) : (n < 14) ? CW'(14 - n) : '0;
            es1 = {n >= 7, n >= 5};
            es2 = {n >= 14, n >= 10};
            checks++;
            if (o_cnt !== {e1, e0}) begin
                errors++;
                $display("FAIL basic_cnt n=%0d: got %h expected %h", n, o_cnt, {e1, e0});
            end
            checks++;
            if ({o_s1wto, o_s2wto, o_irq1, o_irq2} !== {es1, es2, |es1, |es2}) begin
                errors++;
                $display("FAIL basic_flags n=%0d: got s1=%b s2=%b irq=%b%b expected %b %b",
                         n, o_s1wto, o_s2wto, o_irq1, o_irq2, es1, es2);
            end
        end
        i_en = 2'b00;
        step();
        checks++;
        if ({o_cnt, o_s1wto, o_s2wto} !== {32'h0, 2'b11, 2'b11}) begin
            errors++;
            $display("FAIL disable_keeps_flags: got cnt=%h s1=%b s2=%b expected 0 11 11",
                     o_cnt, o_s1wto, o_s2wto);
        end
    endtask

    task automatic test_kicking();
        int n;
        logic seen;
        i_prescale = 20'd3;
        i_timeout[CW-1:0] = 16'd4;
        idle_all();
        i_en = 2'b01;
        step();
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            i_kick[0] = (c % 12 == 11);
            step();
            if (o_s1wto[0]) seen = 1'b1;
        end
        i_kick = '0;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL kick_keepalive: got s1wto seen=%b expected 0", seen);
        end
        n = 0;
        while (!o_s1wto[0] && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n < 13 || n > 19) begin
            errors++;
            $display("FAIL kick_stop_expiry: got %0d cycles expected 13..19", n);
        end
    endtask

    task automatic test_stage2_recovery();
        i_prescale = '0;
        i_timeout[CW-1:0] = 16'd3;
        idle_all();
        i_en = 2'b01;
        repeat (5) step();
        checks++;
        if ({o_s1wto[0], o_s2wto[0], cnt0} !== {2'b10, 16'd2}) begin
            errors++;
            $display("FAIL s2_entry: got s1=%b s2=%b cnt=%0d expected 1 0 2",
                     o_s1wto[0], o_s2wto[0], cnt0);
        end
        i_prescale = 20'd1000;
        step();
        i_kick[0] = 1'b1;
        step();
        i_kick = '0;
        checks++;
        if ({cnt0, o_bad_kick[0], o_s1wto[0]} !== {16'd2, 2'b01}) begin
            errors++;
            $display("FAIL s2_kick_ignored: got cnt=%0d bk=%b s1=%b expected 2 0 1",
                     cnt0, o_bad_kick[0], o_s1wto[0]);
        end
        i_clr_s1[0] = 1'b1;
        step();
        i_clr_s1 = '0;
        checks++;
        if ({cnt0, o_s1wto[0], o_s2wto[0]} !== {16'd3, 2'b00}) begin
            errors++;
            $display("FAIL s2_clr_s1: got cnt=%0d s1=%b s2=%b expected 3 0 0",
                     cnt0, o_s1wto[0], o_s2wto[0]);
        end
        i_prescale = '0;
        step();
        checks++;
        if (cnt0 !== 16'd3) begin
            errors++;
            $display("FAIL prescale_wrap_no_tick: got cnt=%0d expected 3", cnt0);
        end
        repeat (3) step();
        checks++;
        if ({o_s1wto[0], o_s2wto[0], cnt0} !== {2'b10, 16'd3}) begin
            errors++;
            $display("FAIL back_in_s1: got s1=%b s2=%b cnt=%0d expected 1 0 3",
                     o_s1wto[0], o_s2wto[0], cnt0);
        end
    endtask

    task automatic test_window();
        i_prescale = '0;
        i_timeout[CW-1:0] = 16'd10;
        i_window[CW-1:0] = 16'd3;
        idle_all();
        i_en = 2'b01;
        repeat (4) step();
        checks++;
        if (cnt0 !== 16'd7) begin
            errors++;
            $display("FAIL win_setup: got cnt=%0d expected 7", cnt0);
        end
        i_kick[0] = 1'b1;
        step();
        i_kick = '0;
`ifdef WDG_WINDOW_EN
        checks++;
        if ({o_bad_kick[0], o_s1wto[0], cnt0} !== {2'b11, 16'd10}) begin
            errors++;
            $display("FAIL win_early_kick: got bk=%b s1=%b cnt=%0d expected 1 1 10",
                     o_bad_kick[0], o_s1wto[0], cnt0);
        end
        step();
        checks++;
        if ({o_bad_kick[0], cnt0} !== {1'b0, 16'd9}) begin
            errors++;
            $display("FAIL win_pulse_len: got bk=%b cnt=%0d expected 0 9", o_bad_kick[0], cnt0);
        end
        i_clr_s1[0] = 1'b1;
        step();
        i_clr_s1 = '0;
        repeat (8) step();
        i_kick[0] = 1'b1;
        step();
        i_kick = '0;
        checks++;
        if ({o_bad_kick[0], o_s1wto[0], cnt0} !== {2'b00, 16'd10}) begin
            errors++;
            $display("FAIL win_valid_kick: got bk=%b s1=%b cnt=%0d expected 0 0 10",
                     o_bad_kick[0], o_s1wto[0], cnt0);
        end
`else
        checks++;
        if ({o_bad_kick[0], o_s1wto[0], cnt0} !== {2'b00, 16'd10}) begin
            errors++;
            $display("FAIL nowin_kick: got bk=%b s1=%b cnt=%0d expected 0 0 10",
                     o_bad_kick[0], o_s1wto[0], cnt0);
        end
        step();
        checks++;
        if ({o_bad_kick[0], cnt0} !== {1'b0, 16'd9}) begin
            errors++;
            $display("FAIL nowin_after: got bk=%b cnt=%0d expected 0 9", o_bad_kick[0], cnt0);
        end
`endif
        i_window = '1;
    endtask

    task automatic test_edge_cases();
        i_prescale = '0;
        i_timeout[CW-1:0] = 16'd0;
        idle_all();
        i_en = 2'b01;
        step();
        step();
        checks++;
        if ({o_s1wto[0], o_s2wto[0], cnt0} !== {2'b10, 16'd1}) begin
            errors++;
            $display("FAIL zero_timeout_s1: got s1=%b s2=%b cnt=%0d expected 1 0 1",
                     o_s1wto[0], o_s2wto[0], cnt0);
        end
        step();
        checks++;
        if ({o_s2wto[0], cnt0} !== {1'b1, 16'd0}) begin
            errors++;
            $display("FAIL zero_timeout_s2: got s2=%b cnt=%0d expected 1 0", o_s2wto[0], cnt0);
        end
        i_clr_s2[0] = 1'b1;
        step();
        i_clr_s2 = '0;
        checks++;
        if ({o_s1wto[0], o_s2wto[0]} !== 2'b10) begin
            errors++;
            $display("FAIL clr_s2_expired: got s1=%b s2=%b expected 1 0", o_s1wto[0], o_s2wto[0]);
        end
        i_clr_s1[0] = 1'b1;
        step();
        i_clr_s1 = '0;
        checks++;
        if ({o_s1wto[0], cnt0} !== {1'b0, 16'd0}) begin
            errors++;
            $display("FAIL clr_s1_expired: got s1=%b cnt=%0d expected 0 0", o_s1wto[0], cnt0);
        end
        i_timeout[CW-1:0] = 16'd2;
        idle_all();
        i_en = 2'b01;
        step();
        step();
        i_kick[0] = 1'b1;
        step();
        i_kick = '0;
        checks++;
        if ({o_s1wto[0], cnt0} !== {1'b0, 16'd2}) begin
            errors++;
            $display("FAIL kick_vs_expiry: got s1=%b cnt=%0d expected 0 2", o_s1wto[0], cnt0);
        end
        repeat (3) step();
        i_clr_s2[0] = 1'b1;
        step();
        i_clr_s2 = '0;
        checks++;
        if ({o_s1wto[0], o_s2wto[0]} !== 2'b11) begin
            errors++;
            $display("FAIL set_beats_clear: got s1=%b s2=%b expected 1 1", o_s1wto[0], o_s2wto[0]);
        end
    endtask

    task automatic test_reset_mid();
        i_prescale = '0;
        i_timeout[CW-1:0] = 16'd3;
        idle_all();
        i_en = 2'b01;
        repeat (4) step();
        checks++;
        if ({o_s1wto[0], cnt0} !== {1'b1, 16'd3}) begin
            errors++;
            $display("FAIL rmid_setup: got s1=%b cnt=%0d expected 1 3", o_s1wto[0], cnt0);
        end
        #3 res = 1'b1;
        #1;
        checks++;
        if ({o_cnt, o_s1wto, o_s2wto, o_bad_kick, o_irq1, o_irq2} !== '0) begin
            errors++;
            $display("FAIL rmid_async: got cnt=%h s1=%b s2=%b irq=%b%b expected all 0",
                     o_cnt, o_s1wto, o_s2wto, o_irq1, o_irq2);
        end
        #2 res = 1'b0;
        step();
        checks++;
        if ({o_s1wto[0], cnt0} !== {1'b0, 16'd3}) begin
            errors++;
            $display("FAIL rmid_reenter: got s1=%b cnt=%0d expected 0 3", o_s1wto[0], cnt0);
        end
        repeat (3) step();
        checks++;
        if (o_s1wto[0] !== 1'b1) begin
            errors++;
            $display("FAIL rmid_full_timeout: got s1=%b expected 1", o_s1wto[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_expiry();
        test_kicking();
        test_stage2_recovery();
        test_window();
        test_edge_cases();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
